// File: rtl/wb_wr_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
// The WAW kill option is controlled by the WB_WR_ARB_WAW_KILL_EN macro.
package wb_wr_arb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One buffered MDU result; live drops when a younger WB write supersedes it
  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // Which source owns the register-file write port in the current cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_BYP  = 2'd3
  } wr_src_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_wr_arb_if.sv
// Bus bundle between the pipeline/MDU side (master) and the write-port arbiter (slave).
// Handshake: an MDU result transfers on a cycle where mdu_vld_i and mdu_rdy_o are both high.
interface wb_wr_arb_if
  import wb_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
);

  localparam int CW = cnt_width(DEPTH);

  logic          wb_valid_i;
  logic          wb_reg_wr_i;
  logic          wb_mem_to_reg_i;
  logic [4:0]    wb_rd_i;
  logic [31:0]   wb_res_alu_i;
  logic [31:0]   wb_read_data_i;
  logic          mdu_vld_i;
  logic [4:0]    mdu_rd_i;
  logic [31:0]   mdu_data_i;
  logic          mdu_rdy_o;
  logic          rf_wr_en_o;
  logic [4:0]    rf_wr_addr_o;
  logic [31:0]   rf_wr_data_o;
  logic          stall_o;
  logic [CW-1:0] pend_cnt_o;

  modport master (
    output wb_valid_i, wb_reg_wr_i, wb_mem_to_reg_i, wb_rd_i, wb_res_alu_i,
           wb_read_data_i, mdu_vld_i, mdu_rd_i, mdu_data_i,
    input  mdu_rdy_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, stall_o, pend_cnt_o
  );

  modport slave (
    input  wb_valid_i, wb_reg_wr_i, wb_mem_to_reg_i, wb_rd_i, wb_res_alu_i,
           wb_read_data_i, mdu_vld_i, mdu_rd_i, mdu_data_i,
    output mdu_rdy_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, stall_o, pend_cnt_o
  );

endinterface

// File: rtl/wb_wr_arb_fifo.sv
// Circular buffer of MDU results with head peek and occupancy count.
// Under WB_WR_ARB_WAW_KILL_EN a kill port marks every entry with a matching rd dead.
module wb_wr_arb_fifo
  import wb_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  entry_t                        push_entry,
  input  logic                          pop,
`ifdef WB_WR_ARB_WAW_KILL_EN
  input  logic                          kill,
  input  logic [4:0]                    kill_rd,
`endif
  output entry_t                        head,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides which slots are visible
  always_ff @(posedge clk) begin
`ifdef WB_WR_ARB_WAW_KILL_EN
    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i].rd == kill_rd) mem[i].live <= 1'b0;
      end
    end
`endif
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_wr_arb.sv
// Register-file write-port arbiter: WB has priority, MDU results buffer and drain on idle cycles.
// Optional WAW kill of stale buffered results is enabled by WB_WR_ARB_WAW_KILL_EN.
module wb_wr_arb
  import wb_wr_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  wb_wr_arb_if.slave bus
);

  localparam int            CW         = cnt_width(DEPTH);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  entry_t        head;
  entry_t        push_entry;
  logic [CW-1:0] count;
  logic [3:0]    starve_cnt;
  wr_src_t       wr_src;

  logic        empty;
  logic        full;
  logic        wb_win;
  logic        head_wr;
  logic        head_junk;
  logic        mdu_rdy;
  logic        mdu_acc;
  logic        same_rd;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] wb_data;

  logic        rf_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign wb_win    = bus.wb_valid_i & bus.wb_reg_wr_i & (bus.wb_rd_i != REG_ZERO);
  assign wb_data   = bus.wb_mem_to_reg_i ? bus.wb_read_data_i : bus.wb_res_alu_i;
  assign head_wr   = !empty & head.live & (head.rd != REG_ZERO);
  assign head_junk = !empty & !(head.live & (head.rd != REG_ZERO));
  assign mdu_rdy   = reset & !full;
  assign mdu_acc   = bus.mdu_vld_i & mdu_rdy;

`ifdef WB_WR_ARB_WAW_KILL_EN
  // A result for the register WB is writing right now is already stale
  assign same_rd = wb_win & (bus.mdu_rd_i == bus.wb_rd_i);
`else
  assign same_rd = 1'b0;
`endif

  always_comb begin
    wr_src = SRC_NONE;
    if (wb_win)                wr_src = SRC_WB;
    else if (head_wr)          wr_src = SRC_BUF;
    else if (empty && mdu_acc) wr_src = SRC_BYP;
  end

  assign bypass     = (wr_src == SRC_BYP);
  assign push       = mdu_acc & !bypass & !same_rd;
  assign pop        = (wr_src == SRC_BUF) | head_junk;
  assign push_entry = '{live: 1'b1, rd: bus.mdu_rd_i, data: bus.mdu_data_i};

  wb_wr_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
`ifdef WB_WR_ARB_WAW_KILL_EN
    .kill       (wb_win),
    .kill_rd    (bus.wb_rd_i),
`endif
    .head       (head),
    .count      (count)
  );

  // Counts lost arbitrations of a writable head; saturates so stall holds until it drains
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (empty || (wr_src == SRC_BUF)) begin
      starve_cnt <= '0;
    end else if (head_wr && wb_win && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    rf_en   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (reset) begin
      unique case (wr_src)
        SRC_WB: begin
          rf_en   = 1'b1;
          rf_addr = bus.wb_rd_i;
          rf_data = wb_data;
        end
        SRC_BUF: begin
          rf_en   = 1'b1;
          rf_addr = head.rd;
          rf_data = head.data;
        end
        SRC_BYP: begin
          // An r0 result is consumed without touching the port
          if (bus.mdu_rd_i != REG_ZERO) begin
            rf_en   = 1'b1;
            rf_addr = bus.mdu_rd_i;
            rf_data = bus.mdu_data_i;
          end
        end
        default: begin
          rf_en = 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_wr_en_o   = rf_en;
  assign bus.rf_wr_addr_o = rf_addr;
  assign bus.rf_wr_data_o = rf_data;
  assign bus.mdu_rdy_o    = mdu_rdy;
  assign bus.stall_o      = reset & (starve_cnt == STARVE_LIM);
  assign bus.pend_cnt_o   = reset ? count : '0;

endmodule

// File: tb/tb_wb_wr_arb.sv
// Directed bench for wb_wr_arb (DEPTH=2, STARVE_MAX=4); WB_WR_ARB_WAW_KILL_EN selects WAW expectations.
module tb_wb_wr_arb;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [36:0] exp_q[$];
  logic [31:0] rf_model [32];

  wb_wr_arb_if #(.DEPTH(2)) bus ();

  wb_wr_arb #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file that the write port feeds
  always @(posedge clk) begin
    if (reset && bus.rf_wr_en_o) rf_model[bus.rf_wr_addr_o] <= bus.rf_wr_data_o;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic vld, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] load, input logic m2r);
    bus.wb_valid_i      = vld;
    bus.wb_reg_wr_i     = vld;
    bus.wb_rd_i         = rd;
    bus.wb_res_alu_i    = alu;
    bus.wb_read_data_i  = load;
    bus.wb_mem_to_reg_i = m2r;
  endtask

  task automatic drive_mdu(input logic vld, input logic [4:0] rd, input logic [31:0] data);
    bus.mdu_vld_i  = vld;
    bus.mdu_rd_i   = rd;
    bus.mdu_data_i = data;
  endtask

  task automatic drive_idle();
    drive_wb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    drive_mdu(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_wb(1'b1, 5'd5, 32'h11, 32'h22, 1'b1);
    drive_mdu(1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_en got %0h exp 0", bus.rf_wr_en_o); end
      checks++; if (bus.rf_wr_addr_o !== 5'd0) begin errors++; $display("FAIL rst_addr got %0h exp 0", bus.rf_wr_addr_o); end
      checks++; if (bus.rf_wr_data_o !== 32'd0) begin errors++; $display("FAIL rst_data got %0h exp 0", bus.rf_wr_data_o); end
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", bus.stall_o); end
      checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL rst_pend got %0h exp 0", bus.pend_cnt_o); end
      checks++; if (bus.mdu_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_rdy got %0h exp 0", bus.mdu_rdy_o); end
      next_cycle();
    end
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++; if (bus.mdu_rdy_o !== 1'b1) begin errors++; $display("FAIL rel_rdy got %0h exp 1", bus.mdu_rdy_o); end
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL rel_pend got %0h exp 0", bus.pend_cnt_o); end
    checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL rel_en got %0h exp 0", bus.rf_wr_en_o); end
    next_cycle();
  endtask

  task automatic test_wb_priority();
    drive_wb(1'b1, 5'd5, 32'h11, 32'h22, 1'b1);
    drive_mdu(1'b1, 5'd7, 32'h77);
    @(negedge clk);
    checks++; if (bus.rf_wr_en_o !== 1'b1) begin errors++; $display("FAIL wb_en got %0h exp 1", bus.rf_wr_en_o); end
    checks++; if (bus.rf_wr_addr_o !== 5'd5) begin errors++; $display("FAIL wb_addr got %0h exp 5", bus.rf_wr_addr_o); end
    checks++; if (bus.rf_wr_data_o !== 32'h22) begin errors++; $display("FAIL wb_data got %0h exp 22", bus.rf_wr_data_o); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd1) begin errors++; $display("FAIL buf_pend got %0h exp 1", bus.pend_cnt_o); end
    checks++; if (bus.rf_wr_addr_o !== 5'd7) begin errors++; $display("FAIL buf_addr got %0h exp 7", bus.rf_wr_addr_o); end
    checks++; if (bus.rf_wr_data_o !== 32'h77) begin errors++; $display("FAIL buf_data got %0h exp 77", bus.rf_wr_data_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL drained_pend got %0h exp 0", bus.pend_cnt_o); end
    checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL drained_en got %0h exp 0", bus.rf_wr_en_o); end
    next_cycle();
  endtask

  task automatic test_bypass();
    drive_mdu(1'b1, 5'd3, 32'hABCD);
    @(negedge clk);
    checks++; if (bus.rf_wr_en_o !== 1'b1) begin errors++; $display("FAIL byp_en got %0h exp 1", bus.rf_wr_en_o); end
    checks++; if (bus.rf_wr_addr_o !== 5'd3) begin errors++; $display("FAIL byp_addr got %0h exp 3", bus.rf_wr_addr_o); end
    checks++; if (bus.rf_wr_data_o !== 32'hABCD) begin errors++; $display("FAIL byp_data got %0h exp abcd", bus.rf_wr_data_o); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL byp_pend got %0h exp 0", bus.pend_cnt_o); end
    checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL byp_after_en got %0h exp 0", bus.rf_wr_en_o); end
    next_cycle();
  endtask

  task automatic test_starve();
    drive_wb(1'b1, 5'd1, 32'h100, 32'h0, 1'b0);
    drive_mdu(1'b1, 5'd8, 32'h88);
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      drive_wb(1'b1, 5'd1, 32'h100 + k, 32'h0, 1'b0);
      @(negedge clk);
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL starve_stall%0d got %0h exp 0", k, bus.stall_o); end
      checks++; if (bus.rf_wr_data_o !== 32'h100 + k) begin errors++; $display("FAIL starve_wb%0d got %0h exp %0h", k, bus.rf_wr_data_o, 32'h100 + k); end
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_c5 got %0h exp 1", bus.stall_o); end
    checks++; if (bus.rf_wr_en_o !== 1'b1) begin errors++; $display("FAIL stall_drain_en got %0h exp 1", bus.rf_wr_en_o); end
    checks++; if (bus.rf_wr_addr_o !== 5'd8) begin errors++; $display("FAIL stall_drain_addr got %0h exp 8", bus.rf_wr_addr_o); end
    checks++; if (bus.rf_wr_data_o !== 32'h88) begin errors++; $display("FAIL stall_drain_data got %0h exp 88", bus.rf_wr_data_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL stall_c6 got %0h exp 0", bus.stall_o); end
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL stall_c6_pend got %0h exp 0", bus.pend_cnt_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [36:0] e;
    // Cycles 0-3: WB writes every cycle so the buffer fills
    drive_wb(1'b1, 5'd2, 32'h2, 32'h0, 1'b0);
    drive_mdu(1'b1, 5'd10, 32'hA0);
    @(negedge clk);
    checks++; if (bus.mdu_rdy_o !== 1'b1) begin errors++; $display("FAIL fill0_rdy got %0h exp 1", bus.mdu_rdy_o); end
    exp_q.push_back({5'd10, 32'hA0});
    next_cycle();
    drive_mdu(1'b1, 5'd11, 32'hB0);
    @(negedge clk);
    checks++; if (bus.mdu_rdy_o !== 1'b1) begin errors++; $display("FAIL fill1_rdy got %0h exp 1", bus.mdu_rdy_o); end
    exp_q.push_back({5'd11, 32'hB0});
    next_cycle();
    drive_mdu(1'b1, 5'd12, 32'hC0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (bus.mdu_rdy_o !== 1'b0) begin errors++; $display("FAIL full%0d_rdy got %0h exp 0", c, bus.mdu_rdy_o); end
      checks++; if (bus.pend_cnt_o !== 2'd2) begin errors++; $display("FAIL full%0d_pend got %0h exp 2", c, bus.pend_cnt_o); end
      next_cycle();
    end
    // Cycle 4: WB idle, head drains, but no push while still full
    drive_wb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.mdu_rdy_o !== 1'b0) begin errors++; $display("FAIL pop_full_rdy got %0h exp 0", bus.mdu_rdy_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL fill_stall got %0h exp 0", bus.stall_o); end
    e = exp_q.pop_front();
    checks++; if ({bus.rf_wr_en_o, bus.rf_wr_addr_o, bus.rf_wr_data_o} !== {1'b1, e}) begin errors++; $display("FAIL drain_a got %0h exp %0h", {bus.rf_wr_addr_o, bus.rf_wr_data_o}, e); end
    next_cycle();
    // Cycle 5: room again, r12 accepted behind r11
    @(negedge clk);
    checks++; if (bus.mdu_rdy_o !== 1'b1) begin errors++; $display("FAIL c5_rdy got %0h exp 1", bus.mdu_rdy_o); end
    exp_q.push_back({5'd12, 32'hC0});
    e = exp_q.pop_front();
    checks++; if ({bus.rf_wr_en_o, bus.rf_wr_addr_o, bus.rf_wr_data_o} !== {1'b1, e}) begin errors++; $display("FAIL drain_b got %0h exp %0h", {bus.rf_wr_addr_o, bus.rf_wr_data_o}, e); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd1) begin errors++; $display("FAIL c6_pend got %0h exp 1", bus.pend_cnt_o); end
    e = exp_q.pop_front();
    checks++; if ({bus.rf_wr_en_o, bus.rf_wr_addr_o, bus.rf_wr_data_o} !== {1'b1, e}) begin errors++; $display("FAIL drain_c got %0h exp %0h", {bus.rf_wr_addr_o, bus.rf_wr_data_o}, e); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL c7_pend got %0h exp 0", bus.pend_cnt_o); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL drain_left got %0d exp 0", exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_r0();
    drive_wb(1'b1, 5'd0, 32'h55, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL r0_alone_en got %0h exp 0", bus.rf_wr_en_o); end
    next_cycle();
    drive_wb(1'b1, 5'd1, 32'h1, 32'h0, 1'b0);
    drive_mdu(1'b1, 5'd4, 32'h44);
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    drive_wb(1'b1, 5'd0, 32'h99, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.rf_wr_addr_o !== 5'd4) begin errors++; $display("FAIL r0_drain_addr got %0h exp 4", bus.rf_wr_addr_o); end
    checks++; if (bus.rf_wr_data_o !== 32'h44) begin errors++; $display("FAIL r0_drain_data got %0h exp 44", bus.rf_wr_data_o); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL r0_pend got %0h exp 0", bus.pend_cnt_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_wb(1'b1, 5'd1, 32'h1, 32'h0, 1'b0);
    drive_mdu(1'b1, 5'd13, 32'hD0);
    next_cycle();
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %0h exp 0", bus.rf_wr_en_o); end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL mid_rst_pend got %0h exp 0", bus.pend_cnt_o); end
    checks++; if (bus.rf_wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_rst_drain got %0h exp 0", bus.rf_wr_en_o); end
    next_cycle();
  endtask

  task automatic test_waw();
    logic [31:0] exp_r9;
    logic        exp_c2_en;
    logic [1:0]  exp_same_pend;
`ifdef WB_WR_ARB_WAW_KILL_EN
    exp_r9        = 32'h2;
    exp_c2_en     = 1'b0;
    exp_same_pend = 2'd0;
`else
    exp_r9        = 32'h1;
    exp_c2_en     = 1'b1;
    exp_same_pend = 2'd1;
`endif
    drive_wb(1'b1, 5'd1, 32'h1, 32'h0, 1'b0);
    drive_mdu(1'b1, 5'd9, 32'h1);
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    drive_wb(1'b1, 5'd9, 32'h2, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.rf_wr_data_o !== 32'h2) begin errors++; $display("FAIL waw_wb_data got %0h exp 2", bus.rf_wr_data_o); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (bus.rf_wr_en_o !== exp_c2_en) begin errors++; $display("FAIL waw_head_en got %0h exp %0h", bus.rf_wr_en_o, exp_c2_en); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== 2'd0) begin errors++; $display("FAIL waw_pend got %0h exp 0", bus.pend_cnt_o); end
    checks++; if (rf_model[9] !== exp_r9) begin errors++; $display("FAIL waw_r9 got %0h exp %0h", rf_model[9], exp_r9); end
    // Same-cycle MDU result to the register WB writes
    drive_wb(1'b1, 5'd6, 32'h60, 32'h0, 1'b0);
    drive_mdu(1'b1, 5'd6, 32'h61);
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (bus.pend_cnt_o !== exp_same_pend) begin errors++; $display("FAIL same_rd_pend got %0h exp %0h", bus.pend_cnt_o, exp_same_pend); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (rf_model[6] !== (exp_same_pend == 2'd1 ? 32'h61 : 32'h60)) begin errors++; $display("FAIL same_rd_r6 got %0h", rf_model[6]); end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int r = 0; r < 32; r++) rf_model[r] = 32'h0;
    test_reset();
    test_wb_priority();
    test_bypass();
    test_starve();
    test_back_to_back();
    test_r0();
    test_reset_mid();
    test_waw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
